// File: rtl/bram_pkg.sv
// Shared block-RAM definitions: same-port write-mode encodings and a constant clog2.
package bram_pkg;

  localparam int unsigned WM_READ_FIRST  = 0;
  localparam int unsigned WM_WRITE_FIRST = 1;
  localparam int unsigned WM_NO_CHANGE   = 2;

  // Ceiling log2 for elaboration-time sizing; clog2(1) = 0.
  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'(1) << i) < 64'(n)) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/tdp_bram_bytewe_if.sv
// Port A / port B request and response signals of the true dual-port RAM.
interface tdp_bram_bytewe_if #(
  parameter int unsigned RAM_WIDTH  = 32,
  parameter int unsigned NB_COL     = 4,
  parameter int unsigned ADDR_WIDTH = 10
);
  logic                  ena;
  logic [NB_COL-1:0]     wea;
  logic [ADDR_WIDTH-1:0] addra;
  logic [RAM_WIDTH-1:0]  dina;
  logic                  regcea;
  logic [RAM_WIDTH-1:0]  douta;
  logic                  douta_valid;

  logic                  enb;
  logic [NB_COL-1:0]     web;
  logic [ADDR_WIDTH-1:0] addrb;
  logic [RAM_WIDTH-1:0]  dinb;
  logic                  regceb;
  logic [RAM_WIDTH-1:0]  doutb;
  logic                  doutb_valid;

  logic                  collision;

  modport master (
    output ena, wea, addra, dina, regcea,
    output enb, web, addrb, dinb, regceb,
    input  douta, douta_valid, doutb, doutb_valid, collision
  );

  modport slave (
    input  ena, wea, addra, dina, regcea,
    input  enb, web, addrb, dinb, regceb,
    output douta, douta_valid, doutb, doutb_valid, collision
  );
endinterface

// File: rtl/bram_port_out.sv
// Per-port read path: write-mode merge, stage-1/stage-2 data registers,
// output-register clock enable and the matching valid pipeline.
module bram_port_out
  import bram_pkg::*;
#(
  parameter int unsigned RAM_WIDTH  = 32,
  parameter int unsigned BYTE_WIDTH = 8,
  parameter int unsigned NB_COL     = 4,
  parameter int unsigned WRITE_MODE = WM_READ_FIRST,
  parameter int unsigned OUT_REG    = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic [NB_COL-1:0]    we,
  input  logic [RAM_WIDTH-1:0] din,
  input  logic [RAM_WIDTH-1:0] rd_old,
  input  logic                 in_range,
  input  logic                 regce,
  output logic [RAM_WIDTH-1:0] dout,
  output logic                 dout_valid
);

  localparam logic OREG = (OUT_REG != 0);
  localparam logic WF   = (WRITE_MODE == WM_WRITE_FIRST);
  localparam logic NC   = (WRITE_MODE == WM_NO_CHANGE);

  logic                 rd_fire_c;
  logic [RAM_WIDTH-1:0] merged_c;
  logic [RAM_WIDTH-1:0] s1_data;
  logic                 s1_valid;
  logic [RAM_WIDTH-1:0] s2_data;
  logic                 s2_valid;

  // Word presented to stage 1: old data, optionally with this port's new bytes.
  always_comb begin
    rd_fire_c = en & ~(NC & (|we));
    merged_c  = rd_old;
    for (int unsigned i = 0; i < NB_COL; i++) begin
      if (WF && we[i]) merged_c[i*BYTE_WIDTH +: BYTE_WIDTH] = din[i*BYTE_WIDTH +: BYTE_WIDTH];
    end
    if (!in_range) merged_c = '0;
  end

  // With an output register, stage-1 valid is a pending flag held until regce drains it.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_data  <= '0;
      s1_valid <= 1'b0;
      s2_data  <= '0;
      s2_valid <= 1'b0;
    end else begin
      if (rd_fire_c) s1_data <= merged_c;
      s1_valid <= rd_fire_c | (OREG & ~regce & s1_valid);
      if (regce) s2_data <= s1_data;
      s2_valid <= regce & s1_valid;
    end
  end

  assign dout       = OREG ? s2_data  : s1_data;
  assign dout_valid = OREG ? s2_valid : s1_valid;

endmodule

// File: rtl/tdp_bram_bytewe.sv
// Single-clock true dual-port RAM with byte write enables, selectable
// same-port write mode, optional output register and a collision flag.
module tdp_bram_bytewe
  import bram_pkg::*;
#(
  parameter int unsigned RAM_WIDTH  = 32,
  parameter int unsigned RAM_DEPTH  = 1024,
  parameter int unsigned BYTE_WIDTH = 8,
  parameter int unsigned WRITE_MODE = WM_READ_FIRST,
  parameter int unsigned OUT_REG    = 0
) (
  input logic               clk,
  input logic               rst,
  tdp_bram_bytewe_if.slave  bus
);

  localparam int unsigned NB_COL     = RAM_WIDTH / BYTE_WIDTH;
  localparam int unsigned ADDR_WIDTH = (clog2(RAM_DEPTH) < 1) ? 1 : clog2(RAM_DEPTH);
  localparam logic [ADDR_WIDTH:0] DEPTH_L = (ADDR_WIDTH + 1)'(RAM_DEPTH);

  logic                 en_a_c, en_b_c;
  logic                 in_rng_a_c, in_rng_b_c;
  logic [NB_COL-1:0]    wr_a_c, wr_b_c;
  logic [RAM_WIDTH-1:0] old_a_c, old_b_c;
  logic                 collision_q;

  logic [RAM_WIDTH-1:0] mem [RAM_DEPTH];

  assign en_a_c     = bus.ena & ~rst;
  assign en_b_c     = bus.enb & ~rst;
  assign in_rng_a_c = {1'b0, bus.addra} < DEPTH_L;
  assign in_rng_b_c = {1'b0, bus.addrb} < DEPTH_L;
  assign wr_a_c     = (en_a_c && in_rng_a_c) ? bus.wea : '0;
  assign wr_b_c     = (en_b_c && in_rng_b_c) ? bus.web : '0;
  assign old_a_c    = in_rng_a_c ? mem[bus.addra] : '0;
  assign old_b_c    = in_rng_b_c ? mem[bus.addrb] : '0;

  // Port A is written last so it wins bytes both ports enable at the same address.
  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < NB_COL; i++) begin
      if (wr_b_c[i]) mem[bus.addrb][i*BYTE_WIDTH +: BYTE_WIDTH] <= bus.dinb[i*BYTE_WIDTH +: BYTE_WIDTH];
      if (wr_a_c[i]) mem[bus.addra][i*BYTE_WIDTH +: BYTE_WIDTH] <= bus.dina[i*BYTE_WIDTH +: BYTE_WIDTH];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) collision_q <= 1'b0;
    else     collision_q <= en_a_c & en_b_c & (bus.addra == bus.addrb)
                            & ((|bus.wea) | (|bus.web));
  end

  assign bus.collision = collision_q;

  bram_port_out #(
    .RAM_WIDTH (RAM_WIDTH),
    .BYTE_WIDTH(BYTE_WIDTH),
    .NB_COL    (NB_COL),
    .WRITE_MODE(WRITE_MODE),
    .OUT_REG   (OUT_REG)
  ) u_port_a (
    .clk       (clk),
    .rst       (rst),
    .en        (en_a_c),
    .we        (bus.wea),
    .din       (bus.dina),
    .rd_old    (old_a_c),
    .in_range  (in_rng_a_c),
    .regce     (bus.regcea),
    .dout      (bus.douta),
    .dout_valid(bus.douta_valid)
  );

  bram_port_out #(
    .RAM_WIDTH (RAM_WIDTH),
    .BYTE_WIDTH(BYTE_WIDTH),
    .NB_COL    (NB_COL),
    .WRITE_MODE(WRITE_MODE),
    .OUT_REG   (OUT_REG)
  ) u_port_b (
    .clk       (clk),
    .rst       (rst),
    .en        (en_b_c),
    .we        (bus.web),
    .din       (bus.dinb),
    .rd_old    (old_b_c),
    .in_range  (in_rng_b_c),
    .regce     (bus.regceb),
    .dout      (bus.doutb),
    .dout_valid(bus.doutb_valid)
  );

endmodule

// File: doc/tdp_bram_bytewe.md
Name: tdp_bram_bytewe

Overview:
- Parametrised single-clock true dual-port block RAM for Conv2d feature-map and weight buffers.
- Successor to the fixed read-first dual-port BRAM. Adds:
  - per-byte write enables
  - selectable same-port write mode
  - optional output pipeline register with clock enable
  - read-valid strobes
  - a registered cross-port address-collision flag
- Sits between the DMA/line-buffer writers and the convolution MAC array readers.

Parameters:
- RAM_WIDTH, 32, data word width in bits; must be a multiple of BYTE_WIDTH.
- RAM_DEPTH, 1024, number of words; need not be a power of two.
- BYTE_WIDTH, 8, bits per write-enable lane.
- WRITE_MODE, 0, same-port behaviour: 0 = READ_FIRST, 1 = WRITE_FIRST, 2 = NO_CHANGE.
- OUT_REG, 0, 0 gives read latency 1; 1 adds an output register, giving latency 2.
- Derived localparams:
  - NB_COL = RAM_WIDTH/BYTE_WIDTH
  - ADDR_WIDTH = clog2(RAM_DEPTH), minimum 1

Ports:
- clk  in  1  single clock for both ports
- rst  in  1  synchronous, active-high reset
- ena  in  1  port A enable
- wea  in  NB_COL  port A byte write enables
- addra  in  ADDR_WIDTH  port A address
- dina  in  RAM_WIDTH  port A write data
- regcea  in  1  port A output-register clock enable (used only when OUT_REG=1)
- douta  out  RAM_WIDTH  port A read data
- douta_valid  out  1  one-cycle strobe; douta holds a newly completed read
- enb, web, addrb, dinb, regceb  in  same widths as port A  port B equivalents
- doutb  out  RAM_WIDTH  port B read data
- doutb_valid  out  1  port B read strobe
- collision  out  1  registered same-address conflict flag

Behaviour:
- Reset:
  - While rst=1, all enables are gated off: no write, no read.
  - At the next edge: douta/doutb=0, both valid strobes=0, collision=0, all pipeline registers=0.
  - Memory contents are untouched.
  - Reset mid-operation: a read already captured in stage 1 is discarded, and its valid strobe never appears.
- Write: at a posedge with en=1, each byte lane i with we[i]=1 stores din[i*BYTE_WIDTH +: BYTE_WIDTH].
- Read stage 1: at a posedge with en=1, the stage-1 data register loads according to WRITE_MODE:
  - READ_FIRST: old word, for every lane.
  - WRITE_FIRST: lanes with we[i]=1 take new din; other lanes take the old value.
  - NO_CHANGE: if any we bit is set, the register holds its previous value and no valid is produced; otherwise it reads normally.
  - A read is defined as en=1 and not (NO_CHANGE with we!=0). Pure reads (we=0) are valid in all modes.
- Latency and hold:
  - OUT_REG=0: dout = stage-1 register. dout_valid rises in the cycle after capture, for one cycle. Data holds until the next read.
  - OUT_REG=1: the stage-2 register loads from stage 1 when regce=1. The valid strobe pipelines alongside and is asserted only when the stage-2 register actually loads.
  - With regce=0, stage 2 and its pending valid stall. A second read issued while stalled overwrites stage 1; the earlier result is lost, and that is the user's responsibility.
- Cross-port same address (addra==addrb, ena=enb=1, same edge):
  - Both write: bytes enabled on both ports take port A data; bytes enabled on one port only take that port's data.
  - One port writes, the other reads: the reading port returns the old word, regardless of WRITE_MODE.
  - collision=1 one cycle after any same-address access where at least one port writes; otherwise 0.
- Out of range (address >= RAM_DEPTH): the write is ignored. The read returns 0 but still produces a valid strobe.
- No other state is needed; the block is a pure pipeline.

Decomposition:
- Shared package bram_pkg:
  - WRITE_MODE constants: WM_READ_FIRST=0, WM_WRITE_FIRST=1, WM_NO_CHANGE=2
  - clog2 function
  - Reused by future single-port and FIFO wrappers.
- One natural sub-module, bram_port_out, instantiated once per port. It holds:
  - write-mode merge
  - stage-1/stage-2 data registers
  - regce stall
  - valid pipeline
- The memory array and collision logic stay in the top module.

Test Plan:
1. Reset, then write A addr 3 we=4'hF data 32'h0000A5A5. Read B addr 3 (OUT_REG=0) -> doutb=32'h0000A5A5 one cycle after capture; doutb_valid pulses exactly 1 cycle.
2. READ_FIRST: A writes 32'hFFFFFFFF to addr 3 -> douta=32'h0000A5A5 next cycle. Repeat with WRITE_FIRST -> 32'hFFFFFFFF. Repeat with NO_CHANGE -> douta unchanged and douta_valid=0.
3. Byte enables: write 32'h11223344 to addr 5 with we=4'b0101 over a preloaded 32'hAABBCCDD -> read returns 32'hAA22CC44.
4. Same-edge double write to addr 7: A 32'h11111111 we=4'b0011, B 32'h22222222 we=4'b0110 -> contents 32'h00221111 (lane 3 keeps its old value 0); collision=1 for exactly one cycle.
5. OUT_REG=1: issue a read with regcea=0 for 3 cycles, then 1 -> douta and douta_valid appear only on the cycle after regcea rises; latency is 2 when regcea is held 1.
6. Assert rst while a read is in stage 1 -> no valid strobe; outputs=0. Memory at the written address still reads back its prior data after reset.
